axis_fifo_pkt: RTL and testbench

Parametrised single-clock AXI4-Stream FIFO with tlast side-band, fill-level reporting and programmable almost-full/almost-empty flags. It provides an optional packet (store-and-forward) mode. It is the general-purpose stream buffer between AXIS producers and consumers. One flat storage array replaces banked sub-FIFOs, so depth and width are set by parameter.

---
 rtl/axis_fifo_pkt.sv | 132 +++++++++++++
 tb/tb_axis_fifo_pkt.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_pkt.sv
// Single-clock AXI4-Stream FIFO with tlast side-band, fill-level flags and an
// optional store-and-forward packet mode with a cut-through escape when full.
module axis_fifo_pkt #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned PACKET_MODE = 0,
   parameter int unsigned AF_LEVEL    = 4064,
   parameter int unsigned AE_LEVEL    = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   pkt_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam int unsigned ENT_W = DATA_W + 1;
   localparam logic [PTR_W-1:0] AF_C = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0] AE_C = PTR_W'(AE_LEVEL);

   typedef enum logic {ST_IDLE, ST_ESCAPE} state_e;

   logic [ENT_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count_q, count_d, pkt_count_q, pkt_count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             af_q, af_d, ae_q, ae_d;
   logic             s_ready_q, s_ready_d, m_valid_q, m_valid_d;
   state_e           state_q, state_d;

   logic             wr_fire, rd_fire, head_last;
   logic [ENT_W-1:0] head;

   assign head      = mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign head_last = head[DATA_W];
   assign wr_fire   = s_axis_tvalid && s_ready_q;
   assign rd_fire   = m_valid_q && m_axis_tready;

   // Pointer, level and flag next-state; flags are derived from next pointers
   // so they update on the edge of the transfer that causes them.
   always_comb begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(wr_fire);
      rd_ptr_d    = rd_ptr_q + PTR_W'(rd_fire);
      count_d     = wr_ptr_d - rd_ptr_d;
      full_d      = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                    (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
      empty_d     = (wr_ptr_d == rd_ptr_d);
      af_d        = (count_d >= AF_C);
      ae_d        = (count_d <= AE_C);
      pkt_count_d = pkt_count_q + PTR_W'(wr_fire && s_axis_tlast)
                                - PTR_W'(rd_fire && head_last);
      s_ready_d   = !full_d;
   end

   // Escape FSM: tracks a partial packet being drained because the FIFO filled.
   always_comb begin
      state_d   = state_q;
      m_valid_d = !empty_d;
      case (state_q)
         ST_IDLE:   if (rd_fire && (pkt_count_q == '0)) state_d = ST_ESCAPE;
         ST_ESCAPE: if (rd_fire && head_last)           state_d = ST_IDLE;
         default:                                       state_d = ST_IDLE;
      endcase
      if (PACKET_MODE != 0) begin
         m_valid_d = !empty_d && ((pkt_count_d != '0) || full_d || (state_d == ST_ESCAPE));
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pkt_count_q <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         af_q        <= 1'b0;
         ae_q        <= 1'b1;
         s_ready_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         state_q     <= ST_IDLE;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pkt_count_q <= pkt_count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         af_q        <= af_d;
         ae_q        <= ae_d;
         s_ready_q   <= s_ready_d;
         m_valid_q   <= m_valid_d;
         state_q     <= state_d;
      end
   end

   // Storage is not reset; contents are only observable through valid pointers.
   always_ff @(posedge aclk) begin
      if (wr_fire) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
   end

   always @(posedge aclk) begin
      assert ((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))
         else $error("axis_fifo_pkt: illegal AF_LEVEL/AE_LEVEL for depth %0d", DEPTH);
   end

   assign s_axis_tready = s_ready_q;
   assign m_axis_tdata  = head[DATA_W-1:0];
   assign m_axis_tlast  = head_last;
   assign m_axis_tvalid = m_valid_q;
   assign count         = count_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign almost_full   = af_q;
   assign almost_empty  = ae_q;
   assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Scoreboard bench for axis_fifo_pkt: a 4096-deep streaming instance and a
// 16-deep packet-mode instance, each checked against a queue-based model.
module tb_axis_fifo_pkt;

   localparam int unsigned A_DEPTH = 4096, A_AF = 4064, A_AE = 32;
   localparam int unsigned B_DEPTH = 16,   B_AF = 12,   B_AE = 2;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  a_sdata = '0, a_mdata;
   logic        a_slast = 0, a_svalid = 0, a_sready, a_mlast, a_mvalid, a_mready = 0;
   logic [12:0] a_count, a_pkt;
   logic        a_full, a_empty, a_af, a_ae;

   logic [7:0]  b_sdata = '0, b_mdata;
   logic        b_slast = 0, b_svalid = 0, b_sready, b_mlast, b_mvalid, b_mready = 0;
   logic [4:0]  b_count, b_pkt;
   logic        b_full, b_empty, b_af, b_ae;

   axis_fifo_pkt dut_a (
      .aclk(clk), .aresetn(rstn),
      .s_axis_tdata(a_sdata), .s_axis_tlast(a_slast), .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
      .m_axis_tdata(a_mdata), .m_axis_tlast(a_mlast), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
      .count(a_count), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
      .pkt_count(a_pkt));

   axis_fifo_pkt #(.DATA_W(8), .ADDR_W(4), .PACKET_MODE(1), .AF_LEVEL(B_AF), .AE_LEVEL(B_AE)) dut_b (
      .aclk(clk), .aresetn(rstn),
      .s_axis_tdata(b_sdata), .s_axis_tlast(b_slast), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
      .m_axis_tdata(b_mdata), .m_axis_tlast(b_mlast), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
      .count(b_count), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
      .pkt_count(b_pkt));

   int checks = 0, failures = 0;
   logic [8:0] qa[$], qb[$];
   int  a_pkts = 0, b_pkts = 0, a_wr_total = 0;
   bit  a_started = 0, b_started = 0, b_esc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model A: accepted beats queue up, reads pop and compare in order.
   always @(posedge clk or negedge rstn) begin : model_a
      logic [8:0] e;
      if (!rstn) begin
         qa.delete(); a_pkts = 0; a_started = 0;
      end else begin
         a_started = 1;
         if (a_mvalid && a_mready) begin
            if (qa.size() == 0) chk("a_read_when_empty", 32'(1), 32'(0));
            else begin
               e = qa.pop_front();
               chk("a_rd_beat", 32'({a_mlast, a_mdata}), 32'(e));
               if (e[8]) a_pkts--;
            end
         end
         if (a_svalid && a_sready) begin
            qa.push_back({a_slast, a_sdata});
            a_wr_total++;
            if (a_slast) a_pkts++;
         end
      end
   end

   // Reference model B: packet mode; escape begins when a read takes a beat
   // with no complete packet stored and ends when that packet's tlast leaves.
   always @(posedge clk or negedge rstn) begin : model_b
      logic [8:0] e;
      if (!rstn) begin
         qb.delete(); b_pkts = 0; b_started = 0; b_esc = 0;
      end else begin
         b_started = 1;
         if (b_mvalid && b_mready) begin
            if (qb.size() == 0) chk("b_read_when_empty", 32'(1), 32'(0));
            else begin
               e = qb.pop_front();
               chk("b_rd_beat", 32'({b_mlast, b_mdata}), 32'(e));
               if (b_pkts == 0) b_esc = 1;
               if (e[8]) begin b_esc = 0; b_pkts--; end
            end
         end
         if (b_svalid && b_sready) begin
            qb.push_back({b_slast, b_sdata});
            if (b_slast) b_pkts++;
         end
      end
   end

   // Every cycle: levels, flags, ready/valid and head beat against the model.
   always @(negedge clk) begin : flag_check
      int n, m;
      bit vb;
      n = qa.size();
      chk("a_count", 32'(a_count), 32'(n));
      chk("a_full", 32'(a_full), 32'(n == A_DEPTH));
      chk("a_empty", 32'(a_empty), 32'(n == 0));
      chk("a_almost_full", 32'(a_af), 32'(n >= A_AF));
      chk("a_almost_empty", 32'(a_ae), 32'(n <= A_AE));
      chk("a_pkt_count", 32'(a_pkt), 32'(a_pkts));
      chk("a_s_tready", 32'(a_sready), 32'(a_started && n != A_DEPTH));
      chk("a_m_tvalid", 32'(a_mvalid), 32'(n != 0));
      if (n != 0) chk("a_head", 32'({a_mlast, a_mdata}), 32'(qa[0]));
      m = qb.size();
      vb = (m != 0) && (b_pkts != 0 || m == B_DEPTH || b_esc);
      chk("b_count", 32'(b_count), 32'(m));
      chk("b_full", 32'(b_full), 32'(m == B_DEPTH));
      chk("b_empty", 32'(b_empty), 32'(m == 0));
      chk("b_almost_full", 32'(b_af), 32'(m >= B_AF));
      chk("b_almost_empty", 32'(b_ae), 32'(m <= B_AE));
      chk("b_pkt_count", 32'(b_pkt), 32'(b_pkts));
      chk("b_s_tready", 32'(b_sready), 32'(b_started && m != B_DEPTH));
      chk("b_m_tvalid", 32'(b_mvalid), 32'(vb));
      if (vb) chk("b_head", 32'({b_mlast, b_mdata}), 32'(qb[0]));
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit fire, saw_full;
      int k, start;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);

      // Three beats into an empty FIFO with the consumer stalled.
      a_mready = 0;
      a_svalid = 1; a_sdata = 8'h11; a_slast = 0; @(negedge clk);
      chk("a_latency_1cycle", 32'(a_mvalid), 32'(1));
      a_sdata = 8'h22; @(negedge clk);
      a_sdata = 8'h33; a_slast = 1; @(negedge clk);
      a_svalid = 0; a_slast = 0;
      repeat (4) @(negedge clk);
      chk("a_three_count", 32'(a_count), 32'(3));
      chk("a_three_pkt", 32'(a_pkt), 32'(1));
      chk("a_three_head_held", 32'(a_mdata), 32'(8'h11));

      // Fill to full, then a single read frees one slot.
      a_svalid = 1;
      for (int i = 0; i < 5000; i++) begin
         a_sdata = 8'($urandom); a_slast = ($urandom_range(7) == 0);
         @(negedge clk);
         if (!a_sready) break;
      end
      chk("a_fill_full", 32'(a_full), 32'(1));
      chk("a_fill_count", 32'(a_count), 32'(A_DEPTH));
      repeat (2) @(negedge clk);
      a_mready = 1; @(negedge clk);
      a_mready = 0; a_svalid = 0;
      chk("a_after_read_ready", 32'(a_sready), 32'(1));
      chk("a_after_read_count", 32'(a_count), 32'(A_DEPTH - 1));
      a_mready = 1;
      for (int i = 0; i < 5000 && !a_empty; i++) @(negedge clk);
      chk("a_drain1_empty", 32'(a_empty), 32'(1));

      // Randomised streaming with backpressure on both sides, across wraps.
      start = a_wr_total;
      for (int i = 0; i < 50000 && (a_wr_total - start) < 10000; i++) begin
         a_svalid = ($urandom_range(3) != 0);
         a_sdata  = 8'($urandom);
         a_slast  = ($urandom_range(7) == 0);
         a_mready = ($urandom_range(3) != 0);
         @(negedge clk);
      end
      chk("a_random_beats_done", 32'((a_wr_total - start) >= 10000), 32'(1));
      a_svalid = 0; a_mready = 1;
      for (int i = 0; i < 5000 && !a_empty; i++) @(negedge clk);
      chk("a_drain2_empty", 32'(a_empty), 32'(1));
      a_mready = 0;

      // Packet mode: nothing leaves until tlast is stored.
      b_mready = 1;
      for (int i = 0; i < 5; i++) begin
         b_svalid = 1; b_sdata = 8'(8'h50 + i); b_slast = 0; @(negedge clk);
      end
      b_svalid = 0;
      repeat (3) @(negedge clk);
      chk("b_partial_no_valid", 32'(b_mvalid), 32'(0));
      chk("b_partial_count", 32'(b_count), 32'(5));
      b_svalid = 1; b_sdata = 8'h55; b_slast = 1; @(negedge clk);
      b_svalid = 0; b_slast = 0;
      chk("b_pkt_valid_next", 32'(b_mvalid), 32'(1));
      for (int i = 0; i < 100 && !b_empty; i++) @(negedge clk);
      chk("b_pkt_drained", 32'(b_pkt), 32'(0));

      // Packet longer than the depth: cut-through once full.
      b_mready = 0; k = 0; saw_full = 0;
      for (int i = 0; i < 500 && k < 20; i++) begin
         b_svalid = 1; b_sdata = 8'(8'h80 + k); b_slast = (k == 19);
         if (b_full) begin saw_full = 1; b_mready = 1; end
         fire = b_sready;
         @(negedge clk);
         if (fire) k++;
      end
      b_svalid = 0; b_slast = 0;
      chk("b_long_full_seen", 32'(saw_full), 32'(1));
      chk("b_long_all_written", 32'(k), 32'(20));
      b_mready = 1;
      for (int i = 0; i < 200 && !b_empty; i++) @(negedge clk);
      chk("b_long_drained", 32'(b_empty), 32'(1));

      // Random packet traffic, closed with a tlast beat so it can drain.
      for (int i = 0; i < 3000; i++) begin
         b_svalid = ($urandom_range(3) != 0);
         b_sdata  = 8'($urandom);
         b_slast  = ($urandom_range(11) == 0);
         b_mready = ($urandom_range(2) != 0);
         @(negedge clk);
      end
      b_slast = 1; b_svalid = 1; b_mready = 1;
      for (int i = 0; i < 200; i++) begin
         fire = b_sready;
         @(negedge clk);
         if (fire) break;
      end
      b_svalid = 0; b_slast = 0;
      for (int i = 0; i < 500 && !b_empty; i++) @(negedge clk);
      chk("b_random_drained", 32'(b_empty), 32'(1));

      // Asynchronous reset in the middle of a burst.
      a_mready = 0; a_svalid = 1;
      for (int i = 0; i < 100; i++) begin a_sdata = 8'($urandom); a_slast = 0; @(negedge clk); end
      a_svalid = 0;
      chk("a_pre_reset_count", 32'(a_count), 32'(100));
      #2 rstn = 1'b0;
      #1;
      chk("a_rst_count", 32'(a_count), 32'(0));
      chk("a_rst_empty", 32'(a_empty), 32'(1));
      chk("a_rst_mvalid", 32'(a_mvalid), 32'(0));
      chk("a_rst_sready", 32'(a_sready), 32'(0));
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      chk("a_ready_after_release", 32'(a_sready), 32'(1));
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
